// File: rtl/input_harness.sv
// Input harness: drives a wide DUT input bus from one asynchronous pin.
// The pin is synchronised, shifted MSB-first into BITS-wide words, and each
// completed word is XOR-folded into an accumulator. The accumulator value is
// offered to the DUT over valid/ready, with a sticky overrun flag when a
// completed word finds the output still occupied.
//
// Output register states:
//   state       | meaning
//   ST_EMPTY    | no unconsumed word; out_valid=0
//   ST_FULL     | data_out holds a word the DUT has not yet taken; out_valid=1
module input_harness #(
   parameter int BITS        = 64,
   parameter int SYNC_STAGES = 2
) (
   input  logic            fast_clk,
   input  logic            rst_n,
   input  logic            pin_in,
   output logic [BITS-1:0] data_out,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            overrun
);

   localparam int LG_BITS = $clog2(BITS);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   // The top shift-register bit would only ever be shifted out, so just BITS-1
   // bits are stored; the incoming pin_s completes the word.
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [BITS-2:0]        shift_q, shift_d;
   logic [LG_BITS-1:0]     cnt_q, cnt_d;
   logic [BITS-1:0]        acc_q, acc_d;
   logic [BITS-1:0]        data_q, data_d;
   logic                   overrun_q, overrun_d;
   state_t                 state_q, state_d;

   logic                   pin_s;
   logic                   word_done;
   logic [BITS-1:0]        new_word;
   logic [BITS-1:0]        acc_next;

   // Free-running datapath: synchroniser, shifter, bit counter, accumulator.
   always_comb begin
      pin_s     = sync_q[SYNC_STAGES-1];
      sync_d    = {sync_q[SYNC_STAGES-2:0], pin_in};
      new_word  = {shift_q, pin_s};
      shift_d   = new_word[BITS-2:0];
      word_done = (cnt_q == LG_BITS'(BITS - 1));
      cnt_d     = cnt_q + LG_BITS'(1);
      acc_next  = acc_q ^ new_word;
      acc_d     = word_done ? acc_next : acc_q;
   end

   // Output register next state: load, accept, or flag a dropped word.
   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      overrun_d = overrun_q;
      unique case (state_q)
         ST_EMPTY: begin
            if (word_done) begin
               data_d  = acc_next;
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            if (out_ready && word_done) begin
               data_d = acc_next;
            end else if (out_ready) begin
               state_d = ST_EMPTY;
            end else if (word_done) begin
               overrun_d = 1'b1;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // State registers; reset discards any partial word.
   always_ff @(posedge fast_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= '0;
         shift_q   <= '0;
         cnt_q     <= '0;
         acc_q     <= '0;
         data_q    <= '0;
         overrun_q <= 1'b0;
         state_q   <= ST_EMPTY;
      end else begin
         sync_q    <= sync_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         data_q    <= data_d;
         overrun_q <= overrun_d;
         state_q   <= state_d;
      end
   end

   assign data_out  = data_q;
   assign out_valid = (state_q == ST_FULL);
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_input_harness.sv
// Testbench for input_harness at BITS=8, SYNC_STAGES=2: a table of directed
// edge checks, hand-written reset sequences, and a randomized run against a
// word-level reference model.
module tb_input_harness;

   localparam int BITS = 8;
   localparam int SYNC = 2;
   localparam int NRAND = 800;

   logic            fast_clk;
   logic            rst_n;
   logic            pin_in;
   logic [BITS-1:0] data_out;
   logic            out_valid;
   logic            out_ready;
   logic            overrun;

   int vectors;
   int miscompares;

   input_harness #(.BITS(BITS), .SYNC_STAGES(SYNC)) dut (
      .fast_clk (fast_clk),
      .rst_n    (rst_n),
      .pin_in   (pin_in),
      .data_out (data_out),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .overrun  (overrun)
   );

   initial fast_clk = 1'b0;
   always #5 fast_clk = ~fast_clk;

   // pin: constant pin level; mode selects out_ready pattern; edge: check after this edge
   typedef struct {
      logic            pin;
      int              mode;
      int              edge_n;
      logic            valid;
      logic [BITS-1:0] data;
      logic            ovr;
   } vec_t;

   vec_t tbl[20];

   function automatic logic ready_for(int mode, int n);
      case (mode)
         0: return 1'b1;
         1: return (n >= 18);
         2: return (n == 15);
         default: return 1'b0;
      endcase
   endfunction

   task automatic check(string name, logic v, logic [BITS-1:0] d, logic o,
                        logic ev, logic [BITS-1:0] ed, logic eo);
      vectors++;
      if (v !== ev || d !== ed || o !== eo) begin
         miscompares++;
         $display("FAIL %s: got valid=%b data=%02h overrun=%b, expected valid=%b data=%02h overrun=%b",
                  name, v, d, o, ev, ed, eo);
      end
   endtask

   // Hold reset 3 cycles, release at a falling edge; the next rising edge is edge 0.
   task automatic do_reset();
      rst_n     = 1'b0;
      pin_in    = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge fast_clk);
      @(negedge fast_clk);
      rst_n = 1'b1;
   endtask

   task automatic run_edge(logic p, logic r);
      pin_in    = p;
      out_ready = r;
      @(posedge fast_clk);
      #1;
   endtask

   // Word-level reference model state
   bit              hist[NRAND];
   logic            m_valid;
   logic [BITS-1:0] m_data;
   logic [BITS-1:0] m_acc;
   logic            m_ovr;

   function automatic bit pin_s_at(int n);
      return (n >= SYNC) ? hist[n - SYNC] : 1'b0;
   endfunction

   task automatic model_edge(int n, logic r);
      int word;
      if ((n % BITS) == BITS - 1) begin
         word = 0;
         for (int i = 0; i < BITS; i++)
            word = word * 2 + int'(pin_s_at(n - (BITS - 1) + i));
         m_acc = m_acc ^ BITS'(word);
         if (!m_valid) begin
            m_data  = m_acc;
            m_valid = 1'b1;
         end else if (r) begin
            m_data = m_acc;
         end else begin
            m_ovr = 1'b1;
         end
      end else if (m_valid && r) begin
         m_valid = 1'b0;
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;

      tbl[0]  = '{1'b1, 0,  7, 1'b1, 8'h3F, 1'b0};
      tbl[1]  = '{1'b1, 0,  6, 1'b0, 8'h00, 1'b0};
      tbl[2]  = '{1'b1, 0,  8, 1'b0, 8'h3F, 1'b0};
      tbl[3]  = '{1'b1, 0, 15, 1'b1, 8'hC0, 1'b0};
      tbl[4]  = '{1'b1, 0, 16, 1'b0, 8'hC0, 1'b0};
      tbl[5]  = '{1'b1, 0, 23, 1'b1, 8'h3F, 1'b0};
      tbl[6]  = '{1'b0, 0,  7, 1'b1, 8'h00, 1'b0};
      tbl[7]  = '{1'b0, 0,  8, 1'b0, 8'h00, 1'b0};
      tbl[8]  = '{1'b0, 0, 14, 1'b0, 8'h00, 1'b0};
      tbl[9]  = '{1'b0, 0, 15, 1'b1, 8'h00, 1'b0};
      tbl[10] = '{1'b1, 1,  7, 1'b1, 8'h3F, 1'b0};
      tbl[11] = '{1'b1, 1, 14, 1'b1, 8'h3F, 1'b0};
      tbl[12] = '{1'b1, 1, 15, 1'b1, 8'h3F, 1'b1};
      tbl[13] = '{1'b1, 1, 17, 1'b1, 8'h3F, 1'b1};
      tbl[14] = '{1'b1, 1, 18, 1'b0, 8'h3F, 1'b1};
      tbl[15] = '{1'b1, 1, 23, 1'b1, 8'h3F, 1'b1};
      tbl[16] = '{1'b1, 2, 15, 1'b1, 8'hC0, 1'b0};
      tbl[17] = '{1'b1, 2, 16, 1'b1, 8'hC0, 1'b0};
      tbl[18] = '{1'b1, 2, 23, 1'b1, 8'hC0, 1'b1};
      tbl[19] = '{1'b1, 0, 31, 1'b1, 8'hC0, 1'b0};

      // Reset state, both before and after clocks during reset
      rst_n     = 1'b0;
      pin_in    = 1'b1;
      out_ready = 1'b0;
      #2;
      check("reset_initial", out_valid, data_out, overrun, 1'b0, 8'h00, 1'b0);
      repeat (3) @(posedge fast_clk);
      #1;
      check("reset_held", out_valid, data_out, overrun, 1'b0, 8'h00, 1'b0);

      // Directed table
      foreach (tbl[k]) begin
         do_reset();
         for (int n = 0; n <= tbl[k].edge_n; n++)
            run_edge(tbl[k].pin, ready_for(tbl[k].mode, n));
         check($sformatf("table[%0d] mode%0d edge%0d", k, tbl[k].mode, tbl[k].edge_n),
               out_valid, data_out, overrun, tbl[k].valid, tbl[k].data, tbl[k].ovr);
      end

      // Asynchronous reset pulse between edges while a word is valid with overrun set
      do_reset();
      for (int n = 0; n <= 15; n++) run_edge(1'b1, 1'b0);
      check("pre_async_reset", out_valid, data_out, overrun, 1'b1, 8'h3F, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_immediate", out_valid, data_out, overrun, 1'b0, 8'h00, 1'b0);
      @(negedge fast_clk);
      rst_n = 1'b1;
      for (int n = 0; n <= 7; n++) run_edge(1'b1, 1'b1);
      check("after_async_reset_word", out_valid, data_out, overrun, 1'b1, 8'h3F, 1'b0);

      // Reset mid-word (cnt=4) for 2 cycles, partial word discarded
      do_reset();
      for (int n = 0; n <= 3; n++) run_edge(1'b1, 1'b1);
      rst_n = 1'b0;
      repeat (2) @(posedge fast_clk);
      #1;
      check("midword_reset_held", out_valid, data_out, overrun, 1'b0, 8'h00, 1'b0);
      @(negedge fast_clk);
      rst_n = 1'b1;
      for (int n = 0; n <= 6; n++) run_edge(1'b1, 1'b1);
      check("midword_edge6", out_valid, data_out, overrun, 1'b0, 8'h00, 1'b0);
      run_edge(1'b1, 1'b1);
      check("midword_edge7", out_valid, data_out, overrun, 1'b1, 8'h3F, 1'b0);

      // Randomized run against the reference model
      do_reset();
      m_valid = 1'b0;
      m_data  = '0;
      m_acc   = '0;
      m_ovr   = 1'b0;
      for (int n = 0; n < NRAND; n++) begin
         logic p, r;
         p = 1'($urandom_range(0, 1));
         r = ($urandom_range(0, 99) < ((n < NRAND / 2) ? 85 : 10));
         hist[n] = p;
         run_edge(p, r);
         model_edge(n, r);
         check($sformatf("random edge%0d", n), out_valid, data_out, overrun,
               m_valid, m_data, m_ovr);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/input_harness.md
Name: input_harness

Overview:
- Synthesis-harness companion to the pin-compressing output harness. It drives a DUT's wide input bus from a single external pin, so the DUT inputs cannot be constant-folded away.
- An asynchronous pin is synchronised and shifted into a BITS-wide word, then XOR-accumulated.
- Each word is presented to the DUT over a valid/ready handshake, with sticky overrun detection.
- Single clock domain, the DUT's fast clock.

Parameters:
- BITS, 64, output word width; power of 2, at least 2.
- LG_BITS, $clog2(BITS), bit-counter width; derived, never overridden.
- SYNC_STAGES, 2, depth of the pin synchroniser; at least 2.

Ports:
- fast_clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low. Asserting it clears all state immediately; deassertion is assumed synchronous to fast_clk.
- pin_in  input  1  external pin, asynchronous to fast_clk.
- data_out  output  BITS  accumulated word presented to the DUT.
- out_valid  output  1  data_out holds an unconsumed word.
- out_ready  input  1  DUT accepts data_out this cycle (when out_valid=1).
- overrun  output  1  sticky: at least one completed word was not presented because the output was full.

Behaviour:
- Reset (rst_n=0, asynchronous): sync chain=0, shift_reg=0, cnt=0, acc=0, data_out=0, out_valid=0, overrun=0. Reset mid-word discards the partial word; counting restarts at cnt=0 after release.
- Edge numbering: edge n is the n-th rising edge of fast_clk after rst_n deasserts, counting from 0.
- Synchroniser: pin_in passes through SYNC_STAGES flops; pin_s is the last stage. pin_in-to-pin_s latency is SYNC_STAGES edges.
- Shifting: every edge, shift_reg <= {shift_reg[BITS-2:0], pin_s}. This is free-running and never stalls. The first bit shifted in is the MSB of the completed word.
- Counter: cnt (LG_BITS bits) increments every edge and wraps BITS-1 -> 0.
- word_done = (cnt == BITS-1).
- new_word = {shift_reg[BITS-2:0], pin_s}.
- Accumulation: on word_done, acc <= acc ^ new_word (acc_next). This is unconditional; acc updates even if the word is dropped.
- Output register, states EMPTY (out_valid=0) and FULL (out_valid=1):
  - EMPTY & word_done: data_out <= acc_next, go FULL.
  - FULL & out_ready & word_done: data_out <= acc_next, stay FULL (simultaneous accept and load; no gap, no overrun).
  - FULL & out_ready & !word_done: go EMPTY; data_out holds its old value.
  - FULL & !out_ready & word_done: data_out unchanged, stay FULL, overrun <= 1.
  - FULL & !out_ready & !word_done: hold.
- overrun clears only on reset.
- data_out and out_valid are registered outputs with no combinational path from out_ready or pin_in.
- Word latency: a pin_in change reaches data_out no earlier than SYNC_STAGES+1 edges later and no later than SYNC_STAGES+BITS edges later.

Test Plan (BITS=8, SYNC_STAGES=2):
- Reset: hold rst_n=0 for 3 cycles, then pulse rst_n low between edges while out_valid=1 -> data_out=0x00, out_valid=0 and overrun=0 immediately, before any clock edge.
- Constant pin: pin_in=1 from release, out_ready=1 -> at edge 7 out_valid=1 and data_out=0x3F (pin_s is 0 at edges 0-1). At edge 8 out_valid=0. At edge 15 data_out=0xC0 (0x3F^0xFF). At edge 23 data_out=0x3F.
- Pin held low: pin_in=0, out_ready=1 -> out_valid high exactly 1 cycle in 8 (after edges 7, 15, 23…), data_out=0x00, overrun=0.
- Backpressure: pin_in=1, out_ready=0 -> out_valid=1 and data_out=0x3F from edge 7. At edge 15 overrun=1 and data_out stays 0x3F. Then out_ready=1 at edge 18 -> out_valid=0. At edge 23 data_out=0x3F (acc = 0x3F^0xFF^0xFF), overrun still 1.
- Simultaneous accept and load: out_ready=0 until edge 15, out_ready=1 exactly at edge 15 -> out_valid stays 1, data_out=0xC0, overrun=0.
- Reset mid-word: pin_in=1, assert rst_n at cnt=4 for 2 cycles, release -> first word again 0x3F at edge 7 after the new release.
